// File: rtl/instr_decode_stage.sv
// RV32I subset decoder (addi/add/beq/jal) feeding a small FIFO of decoded records.
// Optional macro DECODE_ILLEGAL_TRAP_EN: sticky trap on illegal push, blocks further input.
module instr_decode_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int DIR_WIDTH  = 5,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_instr,
   output logic                  dec_valid,
   input  logic                  dec_ready,
   output logic [1:0]            dec_op,
   output logic [DIR_WIDTH-1:0]  dec_rd,
   output logic [DIR_WIDTH-1:0]  dec_rs1,
   output logic [DIR_WIDTH-1:0]  dec_rs2,
   output logic [DATA_WIDTH-1:0] dec_imm,
   output logic                  dec_illegal,
   output logic [CNT_WIDTH-1:0]  dec_count,
   output logic                  trap
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [6:0] OPC_ADDI = 7'b0010011;
   localparam logic [6:0] OPC_ADD  = 7'b0110011;
   localparam logic [6:0] OPC_BEQ  = 7'b1100011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;

   localparam logic [1:0] OP_ADDI = 2'd0;
   localparam logic [1:0] OP_ADD  = 2'd1;
   localparam logic [1:0] OP_BEQ  = 2'd2;
   localparam logic [1:0] OP_JAL  = 2'd3;

   typedef struct packed {
      logic [1:0]            op;
      logic [DIR_WIDTH-1:0]  rd;
      logic [DIR_WIDTH-1:0]  rs1;
      logic [DIR_WIDTH-1:0]  rs2;
      logic [DATA_WIDTH-1:0] imm;
      logic                  illegal;
   } rec_t;

   rec_t                 new_rec;
   rec_t                 head_rec;
   rec_t                 out_rec_reg;
   rec_t                 mem_reg [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [OCC_W-1:0]     occ_reg, occ_next;
   logic                 dec_valid_reg;
   logic [CNT_WIDTH-1:0] dec_count_reg;
   logic                 has_space;
   logic                 push;
   logic                 pop;

   logic [2:0] funct3;
   logic [6:0] funct7;
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   // Anything that is not a fully matching encoding decodes to an all-zero illegal record.
   always_comb begin
      new_rec = '0;
      case (in_instr[6:0])
         OPC_ADDI: begin
            if (funct3 == 3'b000) begin
               new_rec.op  = OP_ADDI;
               new_rec.rd  = DIR_WIDTH'(in_instr[11:7]);
               new_rec.rs1 = DIR_WIDTH'(in_instr[19:15]);
               new_rec.imm = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
            end else begin
               new_rec.illegal = 1'b1;
            end
         end
         OPC_ADD: begin
            if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
               new_rec.op  = OP_ADD;
               new_rec.rd  = DIR_WIDTH'(in_instr[11:7]);
               new_rec.rs1 = DIR_WIDTH'(in_instr[19:15]);
               new_rec.rs2 = DIR_WIDTH'(in_instr[24:20]);
            end else begin
               new_rec.illegal = 1'b1;
            end
         end
         OPC_BEQ: begin
            if (funct3 == 3'b000) begin
               new_rec.op  = OP_BEQ;
               new_rec.rs1 = DIR_WIDTH'(in_instr[19:15]);
               new_rec.rs2 = DIR_WIDTH'(in_instr[24:20]);
               new_rec.imm = {{(DATA_WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            end else begin
               new_rec.illegal = 1'b1;
            end
         end
         OPC_JAL: begin
            new_rec.op  = OP_JAL;
            new_rec.rd  = DIR_WIDTH'(in_instr[11:7]);
            new_rec.imm = {{(DATA_WIDTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
         end
         default: new_rec.illegal = 1'b1;
      endcase
   end

   assign has_space = (occ_reg < OCC_W'(FIFO_DEPTH));
   assign push      = in_valid & in_ready;
   assign pop       = dec_valid_reg & dec_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic trap_reg;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         trap_reg <= 1'b0;
      end else if (push && new_rec.illegal) begin
         trap_reg <= 1'b1;
      end
   end

   assign trap     = trap_reg;
   assign in_ready = has_space & ~trap_reg;
`else
   assign trap     = 1'b0;
   assign in_ready = has_space;
`endif

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      occ_next    = occ_reg;
      if (push) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   occ_next = occ_reg + OCC_W'(1);
         2'b01:   occ_next = occ_reg - OCC_W'(1);
         default: occ_next = occ_reg;
      endcase
   end

   // The slot being written this edge can only be the next head when the queue would
   // otherwise be empty, so forward the fresh record instead of the stale storage.
   always_comb begin
      head_rec = mem_reg[rd_ptr_next];
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
         head_rec = new_rec;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= new_rec;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         occ_reg       <= '0;
         dec_valid_reg <= 1'b0;
         out_rec_reg   <= '0;
         dec_count_reg <= '0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         occ_reg       <= occ_next;
         dec_valid_reg <= (occ_next != '0);
         if (occ_next != '0) begin
            out_rec_reg <= head_rec;
         end
         if (pop) begin
            dec_count_reg <= dec_count_reg + CNT_WIDTH'(1);
         end
      end
   end

   assign dec_valid   = dec_valid_reg;
   assign dec_op      = out_rec_reg.op;
   assign dec_rd      = out_rec_reg.rd;
   assign dec_rs1     = out_rec_reg.rs1;
   assign dec_rs2     = out_rec_reg.rs2;
   assign dec_imm     = out_rec_reg.imm;
   assign dec_illegal = out_rec_reg.illegal;
   assign dec_count   = dec_count_reg;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: stimulus queues expected records, a monitor pops and compares.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        dec_valid;
   logic        dec_ready;
   logic [1:0]  dec_op;
   logic [4:0]  dec_rd, dec_rs1, dec_rs2;
   logic [31:0] dec_imm;
   logic        dec_illegal;
   logic [15:0] dec_count;
   logic        trap;

   typedef struct packed {
      logic [1:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        illegal;
   } exp_t;

   exp_t q[$];
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   exp_count = 0;

   instr_decode_stage dut (
      .clk(clk), .arst_n(arst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_imm(dec_imm), .dec_illegal(dec_illegal), .dec_count(dec_count), .trap(trap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm, input logic ill);
      exp_t e;
      e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.illegal = ill;
      return e;
   endfunction

   function automatic exp_t ill_rec();
      return mk(2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
   endfunction

   // Monitor: a record is consumed at the edge following a negedge where valid&ready hold.
   always @(negedge clk) begin
      if (arst_n === 1'b1 && dec_valid === 1'b1 && dec_ready === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_record", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("op", 32'(dec_op), 32'(e.op));
            check("rd", 32'(dec_rd), 32'(e.rd));
            check("rs1", 32'(dec_rs1), 32'(e.rs1));
            check("rs2", 32'(dec_rs2), 32'(e.rs2));
            check("imm", dec_imm, e.imm);
            check("illegal", 32'(dec_illegal), 32'(e.illegal));
            $display("pop #%0d op=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%08h ill=%0d",
                     exp_count, dec_op, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_illegal);
            exp_count++;
         end
      end
   end

   // Called just after a rising edge; returns just after the next rising edge.
   task automatic drive_cycle(input logic v, input logic [31:0] w, input exp_t e,
                              output logic acc, output logic vld);
      in_valid = v;
      in_instr = w;
      @(negedge clk);
      acc = v & in_ready;
      vld = dec_valid;
      if (acc) begin
         q.push_back(e);
         $display("push 0x%08h", w);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   initial begin
      logic        acc, vld;
      int          base;
      logic [4:0]  r1, r2, r3;
      logic [11:0] i12;
      logic [12:0] i13;
      logic [20:0] i21;
      logic [31:0] w;
      exp_t        e;

      arst_n    = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'd0;
      dec_ready = 1'b0;
      #12;
      check("rst_dec_valid", 32'(dec_valid), 32'd0);
      check("rst_dec_count", 32'(dec_count), 32'd0);
      check("rst_trap", 32'(trap), 32'd0);
      check("rst_fields", {dec_imm[31:18] | dec_imm[17:0], dec_op, dec_rd, dec_rs1, dec_rs2}, 32'd0);
      arst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Reset mid-operation discards queued records
      drive_cycle(1'b1, 32'hFFF18293, mk(2'd0, 5'd5, 5'd3, 5'd0, 32'hFFFFFFFF, 1'b0), acc, vld);
      drive_cycle(1'b1, 32'h003100B3, mk(2'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0), acc, vld);
      in_valid = 1'b0;
      check("pre_rst_valid", 32'(dec_valid), 32'd1);
      arst_n = 1'b0;
      #1;
      check("midrst_dec_valid", 32'(dec_valid), 32'd0);
      check("midrst_dec_count", 32'(dec_count), 32'd0);
      q.delete();
      exp_count = 0;
      #2;
      arst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // addi, add, add with bit 30 set (illegal)
      dec_ready = 1'b1;
      drive_cycle(1'b1, 32'hFFF18293, mk(2'd0, 5'd5, 5'd3, 5'd0, 32'hFFFFFFFF, 1'b0), acc, vld);
      check("addi_acc", 32'(acc), 32'd1);
      idle(2);
      drive_cycle(1'b1, 32'h003100B3, mk(2'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0), acc, vld);
      check("add_acc", 32'(acc), 32'd1);
      drive_cycle(1'b1, 32'h403100B3, ill_rec(), acc, vld);
      check("add_bad_acc", 32'(acc), 32'd1);
      idle(3);

      // beq then jal into a stalled consumer; third word must be ignored
      dec_ready = 1'b0;
      drive_cycle(1'b1, 32'h00208463, mk(2'd2, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0), acc, vld);
      check("beq_acc", 32'(acc), 32'd1);
      drive_cycle(1'b1, 32'hFFDFF0EF, mk(2'd3, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0), acc, vld);
      check("jal_acc", 32'(acc), 32'd1);
      drive_cycle(1'b1, 32'h003100B3, ill_rec(), acc, vld);
      check("full_ignore", 32'(acc), 32'd0);
      drive_cycle(1'b1, 32'h0000007F, ill_rec(), acc, vld);
      check("full_ignore2", 32'(acc), 32'd0);
      check("full_in_ready", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      dec_ready = 1'b1;
      idle(4);
      check("count_after_full", 32'(dec_count), 32'd5);
      check("queue_after_full", q.size(), 32'd0);

      // Streaming: back-to-back pushes and pops
      base = exp_count;
      for (int i = 0; i < 20; i++) begin
         r1 = 5'($urandom_range(31));
         r2 = 5'($urandom_range(31));
         r3 = 5'($urandom_range(31));
         case (i % 4)
            0: begin
               i12 = 12'($urandom_range(4095));
               w = enc_addi(r1, r2, i12);
               e = mk(2'd0, r1, r2, 5'd0, {{20{i12[11]}}, i12}, 1'b0);
            end
            1: begin
               w = enc_add(r1, r2, r3);
               e = mk(2'd1, r1, r2, r3, 32'd0, 1'b0);
            end
            2: begin
               i13 = {12'($urandom_range(4095)), 1'b0};
               w = enc_beq(r2, r3, i13);
               e = mk(2'd2, 5'd0, r2, r3, {{19{i13[12]}}, i13}, 1'b0);
            end
            default: begin
               i21 = {20'($urandom_range(1048575)), 1'b0};
               w = enc_jal(r1, i21);
               e = mk(2'd3, r1, 5'd0, 5'd0, {{11{i21[20]}}, i21}, 1'b0);
            end
         endcase
         drive_cycle(1'b1, w, e, acc, vld);
         check("stream_acc", 32'(acc), 32'd1);
         if (i > 0) check("stream_no_bubble", 32'(vld), 32'd1);
      end
      idle(3);
      check("stream_count", 32'(dec_count), 32'((base + 20) & 16'hFFFF));
      check("stream_queue", q.size(), 32'd0);

      // Illegal opcode and optional trap
      drive_cycle(1'b1, 32'h0000007F, ill_rec(), acc, vld);
      check("ill_acc", 32'(acc), 32'd1);
      idle(3);
`ifdef DECODE_ILLEGAL_TRAP_EN
      check("trap_set", 32'(trap), 32'd1);
      check("trap_in_ready", 32'(in_ready), 32'd0);
      drive_cycle(1'b1, 32'hFFF18293, mk(2'd0, 5'd5, 5'd3, 5'd0, 32'hFFFFFFFF, 1'b0), acc, vld);
      check("trap_blocks", 32'(acc), 32'd0);
      idle(2);
      check("trap_sticky", 32'(trap), 32'd1);
      arst_n = 1'b0;
      #1;
      check("trap_rst", 32'(trap), 32'd0);
      #2;
      arst_n = 1'b1;
      q.delete();
      exp_count = 0;
      @(posedge clk); #1;
      check("trap_rst_in_ready", 32'(in_ready), 32'd1);
`else
      check("trap_off", 32'(trap), 32'd0);
      drive_cycle(1'b1, 32'hFFF18293, mk(2'd0, 5'd5, 5'd3, 5'd0, 32'hFFFFFFFF, 1'b0), acc, vld);
      check("after_ill_acc", 32'(acc), 32'd1);
      idle(3);
`endif

      for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
      check("final_drain", q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
